// File: rtl/ppc_pkg.sv
// Shared PowerPC front-end types and widths.
package ppc_pkg;
    localparam int INST_W    = 32;
    localparam int DWORD_W   = 64;
    localparam int MEMADDR_W = 61;

    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t INST_NOP = '0;
endpackage

// File: rtl/fetch_queue_ram.sv
// Instruction queue storage: two write ports at wrAddr/wrAddr+1, two async reads at rdAddr/rdAddr+1.
module fetch_queue_ram
    import ppc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             we0,
    input  logic             we1,
    input  logic [PTR_W-1:0] wrAddr,
    input  inst_t            wrData0,
    input  inst_t            wrData1,
    input  logic [PTR_W-1:0] rdAddr,
    output inst_t            rdData0,
    output inst_t            rdData1
);
    inst_t            mem [DEPTH];
    logic [PTR_W-1:0] wrAddr1;
    logic [PTR_W-1:0] rdAddr1;

    // Second port addresses wrap naturally at the pointer width.
    assign wrAddr1 = wrAddr + PTR_W'(1);
    assign rdAddr1 = rdAddr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (we0) mem[wrAddr]  <= wrData0;
        if (we1) mem[wrAddr1] <= wrData1;
    end

    assign rdData0 = mem[rdAddr];
    assign rdData1 = mem[rdAddr1];
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues doubleword reads, buffers instructions in a circular queue, feeds D0/D1.
module fetch_queue
    import ppc_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          PTR_W    = 6,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 memReadEn,
    output logic [MEMADDR_W-1:0] memReadAddr,
    input  logic [DWORD_W-1:0]   memReadData,
    output inst_t                D0inst,
    output logic                 D0valid,
    output inst_t                D1inst,
    output logic                 D1valid,
    input  logic [1:0]           pop,
    input  logic                 redirectEn,
    input  logic [63:0]          redirectPc,
    input  logic                 haltFetch,
    output logic [PTR_W:0]       count
);
    localparam int NEED_W = PTR_W + 3;

    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    countQ;
    logic [63:0]       fetchPc;
    logic              inflight, skipFirst;
    logic [1:0]        popReq, popEff, pushNum;
    logic [NEED_W-1:0] need;
    logic              we0, we1;
    inst_t             wrData0, wrData1, rdData0, rdData1;

    always_comb begin
        popReq = (pop == 2'd3) ? 2'd2 : pop;
        popEff = popReq;
        if (countQ < (PTR_W+1)'(popReq)) popEff = countQ[1:0];
    end

    // Data bits [63:32] hold the lower-address (big-endian first) instruction.
    assign pushNum = (inflight && !redirectEn) ? (skipFirst ? 2'd1 : 2'd2) : 2'd0;
    assign we0     = (pushNum != 2'd0);
    assign we1     = (pushNum == 2'd2);
    assign wrData0 = skipFirst ? memReadData[31:0] : memReadData[63:32];
    assign wrData1 = memReadData[31:0];

    // Reserve room for the word already in flight plus the one about to be requested.
    always_comb begin
        need = NEED_W'(countQ) - NEED_W'(popEff) + (inflight ? NEED_W'(4) : NEED_W'(2));
        memReadEn = !reset && !redirectEn && !haltFetch && (need <= NEED_W'(DEPTH));
    end

    assign memReadAddr = fetchPc[63:3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            countQ    <= '0;
            fetchPc   <= RESET_PC;
            inflight  <= 1'b0;
            skipFirst <= 1'b0;
        end else if (redirectEn) begin
            head      <= '0;
            tail      <= '0;
            countQ    <= '0;
            inflight  <= 1'b0;
            fetchPc   <= {redirectPc[63:3], 3'b000};
            skipFirst <= redirectPc[2];
        end else begin
            head     <= head + PTR_W'(popEff);
            tail     <= tail + PTR_W'(pushNum);
            countQ   <= countQ + (PTR_W+1)'(pushNum) - (PTR_W+1)'(popEff);
            inflight <= memReadEn;
            if (memReadEn) fetchPc <= {fetchPc[63:3] + 61'd1, 3'b000};
            if (inflight) skipFirst <= 1'b0;
        end
    end

    fetch_queue_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clk     (clk),
        .we0     (we0),
        .we1     (we1),
        .wrAddr  (tail),
        .wrData0 (wrData0),
        .wrData1 (wrData1),
        .rdAddr  (head),
        .rdData0 (rdData0),
        .rdData1 (rdData1)
    );

    assign D0valid = (countQ != '0);
    assign D1valid = (countQ >= (PTR_W+1)'(2));
    assign D0inst  = D0valid ? rdData0 : INST_NOP;
    assign D1inst  = D1valid ? rdData1 : INST_NOP;
    assign count   = countQ;

    always @(posedge clk) begin
        if (!reset && !redirectEn) begin
            assert (pop != 2'd3) else $error("fetch_queue: illegal pop=3");
            assert ((PTR_W+1)'(pop) <= countQ) else $error("fetch_queue: pop exceeds count");
            assert (NEED_W'(countQ) + NEED_W'(pushNum) - NEED_W'(popEff) <= NEED_W'(DEPTH))
                else $error("fetch_queue: queue overflow");
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a one-cycle-latency memory model.
module tb_fetch_queue;
    import ppc_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           memReadEn;
    logic [60:0]    memReadAddr;
    logic [63:0]    memReadData = 64'hDEADBEEF_DEADBEEF;
    inst_t          D0inst, D1inst;
    logic           D0valid, D1valid;
    logic [1:0]     pop;
    logic           redirectEn;
    logic [63:0]    redirectPc;
    logic           haltFetch;
    logic [6:0]     count;

    logic           fixedMode;
    int             checks = 0;
    int             errors = 0;
    logic [31:0]    expIdx;

    fetch_queue #(.DEPTH(64), .PTR_W(6), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .memReadEn   (memReadEn),
        .memReadAddr (memReadAddr),
        .memReadData (memReadData),
        .D0inst      (D0inst),
        .D0valid     (D0valid),
        .D1inst      (D1inst),
        .D1valid     (D1valid),
        .pop         (pop),
        .redirectEn  (redirectEn),
        .redirectPc  (redirectPc),
        .haltFetch   (haltFetch),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Memory: word index of each instruction equals its value (dword a -> 2a, 2a+1).
    always @(posedge clk) begin
        if (memReadEn)
            memReadData <= fixedMode ? 64'h7C221A14_38600001
                                     : {memReadAddr[30:0], 1'b0, memReadAddr[30:0], 1'b1};
        else
            memReadData <= 64'hDEADBEEF_DEADBEEF;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pop = 2'd0; redirectEn = 1'b0; redirectPc = 64'h0;
        haltFetch = 1'b0; fixedMode = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst d0valid", D0valid, 0);
        checkVal("rst d1valid", D1valid, 0);
        checkVal("rst d0inst", D0inst, 0);
        checkVal("rst d1inst", D1inst, 0);
        checkVal("rst count", count, 0);
        checkVal("rst memen", memReadEn, 0);

        reset = 1'b0;
        #1;
        checkVal("first memen", memReadEn, 1);
        checkVal("first addr", memReadAddr, 0);
        tick();
        checkVal("edge1 addr", memReadAddr, 1);
        checkVal("edge1 count", count, 0);
        tick();
        checkVal("edge2 d0inst", D0inst, 32'h7C221A14);
        checkVal("edge2 d1inst", D1inst, 32'h38600001);
        checkVal("edge2 d0valid", D0valid, 1);
        checkVal("edge2 d1valid", D1valid, 1);
        checkVal("edge2 count", count, 2);
        checkVal("edge2 addr", memReadAddr, 2);

        // Restart at PC 0 with indexed data, then fill without popping.
        fixedMode = 1'b0;
        redirectEn = 1'b1; redirectPc = 64'h0;
        tick();
        redirectEn = 1'b0;
        checkVal("redir0 count", count, 0);
        repeat (40) tick();
        checkVal("full count", count, 64);
        checkVal("full memen", memReadEn, 0);
        checkVal("full d0inst", D0inst, 0);
        checkVal("full d1inst", D1inst, 1);
        checkVal("full addr", memReadAddr, 32);

        pop = 2'd2;
        #1;
        checkVal("resume memen", memReadEn, 1);
        tick();
        checkVal("pop2 count", count, 62);
        checkVal("pop2 d0inst", D0inst, 2);
        expIdx = 32'd2;

        // Steady single pops while fetching: pointers wrap several times.
        pop = 2'd1;
        for (int i = 0; i < 150; i++) begin
            tick();
            expIdx = expIdx + 32'd1;
            checkVal("wrap d0inst", D0inst, expIdx);
        end
        checkVal("wrap d1inst", D1inst, expIdx + 32'd1);
        checkVal("wrap d0valid", D0valid, 1);

        // Redirect to 0x104: only the second word of dword 0x20 is queued.
        redirectEn = 1'b1; redirectPc = 64'h104; pop = 2'd2;
        tick();
        redirectEn = 1'b0; pop = 2'd0;
        checkVal("r104 count", count, 0);
        checkVal("r104 d0valid", D0valid, 0);
        checkVal("r104 d0inst", D0inst, 0);
        #1;
        checkVal("r104 memen", memReadEn, 1);
        checkVal("r104 addr", memReadAddr, 61'h20);
        tick();
        checkVal("r104 wait count", count, 0);
        tick();
        checkVal("skip count", count, 1);
        checkVal("skip d0inst", D0inst, 32'h41);
        checkVal("skip d0valid", D0valid, 1);
        checkVal("skip d1valid", D1valid, 0);
        checkVal("skip d1inst", D1inst, 0);

        // Redirect while dword 0x21 is returning: that data must vanish.
        redirectEn = 1'b1; redirectPc = 64'h200; pop = 2'd2;
        tick();
        redirectEn = 1'b0; pop = 2'd0;
        checkVal("drop count", count, 0);
        checkVal("drop d0valid", D0valid, 0);
        #1;
        checkVal("drop memen", memReadEn, 1);
        checkVal("drop addr", memReadAddr, 61'h40);
        tick();
        tick();
        checkVal("r200 count", count, 2);
        checkVal("r200 d0inst", D0inst, 32'h80);
        checkVal("r200 d1inst", D1inst, 32'h81);

        // Halt: outstanding response still lands, no new request.
        haltFetch = 1'b1; pop = 2'd1;
        #1;
        checkVal("halt memen", memReadEn, 0);
        tick();
        pop = 2'd0;
        checkVal("halt count", count, 3);
        checkVal("halt d0inst", D0inst, 32'h81);
        tick();
        checkVal("halt hold count", count, 3);
        checkVal("halt hold memen", memReadEn, 0);
        haltFetch = 1'b0;
        #1;
        checkVal("unhalt memen", memReadEn, 1);
        checkVal("unhalt addr", memReadAddr, 61'h42);

        // Reset with a word in flight.
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkVal("midrst d0valid", D0valid, 0);
        checkVal("midrst d0inst", D0inst, 0);
        checkVal("midrst count", count, 0);
        checkVal("midrst memen", memReadEn, 0);
        tick();
        reset = 1'b0;
        #1;
        checkVal("postrst memen", memReadEn, 1);
        checkVal("postrst addr", memReadAddr, 0);
        checkVal("postrst count", count, 0);
        tick();
        tick();
        checkVal("postrst fill count", count, 2);
        checkVal("postrst d0inst", D0inst, 0);
        checkVal("postrst d1inst", D1inst, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Front-end fetch stage of the dual-issue 64-bit PowerPC pipeline.
- Reads 64-bit aligned words (two big-endian 32-bit instructions) from memory read port 0 and buffers them in a circular instruction queue.
- Presents the two oldest instructions to decode slots D0/D1.
- Decode pops 0, 1 or 2 instructions per cycle. A redirect flushes the queue and restarts fetch at a new PC.

Parameters:
- DEPTH, 64, queue entries (32-bit instructions each); must be a power of two, at least 4.
- PTR_W, 6, log2(DEPTH); head/tail pointer width.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high.
- memReadEn  output  1  fetch request this cycle.
- memReadAddr  output  61  doubleword address, equal to fetchPc[0:60].
- memReadData  input  64  fetch data, valid exactly one cycle after memReadEn; bits [0:31] are the lower-address instruction.
- D0inst  output  32  oldest queued instruction.
- D0valid  output  1  D0inst holds a real instruction.
- D1inst  output  32  second-oldest queued instruction.
- D1valid  output  1  D1inst holds a real instruction.
- pop  input  2  instructions consumed by decode this cycle (0..2).
- redirectEn  input  1  flush and restart fetch.
- redirectPc  input  64  new fetch PC, word aligned (bits 62:63 = 0).
- haltFetch  input  1  stop issuing new fetch requests (sc-exit drain).
- count  output  PTR_W+1  valid entries in the queue.

Behaviour:
- Reset (async): head=0, tail=0, count=0, fetchPc=RESET_PC, inflight=0, skipFirst=0, memReadEn=0.
  - D0valid=D1valid=0; D0inst=D1inst=0.
- Outputs are combinational from registered state:
  - D0inst=queue[head], D1inst=queue[head+1] (mod DEPTH).
  - D0valid=(count>=1), D1valid=(count>=2).
  - When not valid, an instruction output reads 0.
- Fetch request rule: memReadEn=1 when all of the following hold:
  - not redirectEn, not haltFetch;
  - (count − popEff + 2·inflight + 2) <= DEPTH.
  - This free-space check counts the in-flight word and is conservative.
  - On a request: inflight<=1, fetchPc <= {fetchPc[0:60]+1, 3'b000}.
- Data return (cycle after request, inflight=1, no redirect):
  - skipFirst=0: write memReadData[0:31] to queue[tail] and memReadData[32:63] to queue[tail+1]; tail+=2.
  - skipFirst=1: write only memReadData[32:63] to queue[tail]; tail+=1; then clear skipFirst.
  - inflight clears unless a new request issues in the same cycle. Back-to-back requests give one word per cycle.
- Pop:
  - popEff = min(pop, count). head += popEff; count += pushed − popEff.
  - pop=3 or pop>count is illegal and must fire a simulation assertion; the RTL clamps it.
- Redirect (highest priority, same edge):
  - head<=0, tail<=0, count<=0, inflight<=0.
  - Data returning that cycle is discarded; pop is ignored.
  - fetchPc <= {redirectPc[0:60],3'b000}; skipFirst <= redirectPc[61].
  - First request issues the cycle after redirect.
- Simultaneous push and pop in one cycle are both honoured. The queue never overflows by construction; an overflow must fire an assertion.
- Wrap-around: head, tail and head+1 wrap modulo DEPTH; a 2-instruction push straddling DEPTH-1→0 is legal.
- haltFetch: an outstanding response is still accepted and pops continue; no new request is issued while it is asserted.
- Reset mid-operation clears everything immediately; in-flight data is never written.
- Latency: redirect at edge N → memReadEn=1 during cycle N+1 → D0valid=1 after edge N+2.

Decomposition:
- Shared package ppc_pkg holds:
  - INST_W=32, DWORD_W=64, MEMADDR_W=61;
  - the instruction word typedef;
  - the NOP/zero instruction constant.
- One sub-module is natural: fetch_queue_ram, a DEPTH x 32 storage with two write ports (tail, tail+1) and two combinational read ports (head, head+1).
- Pointer/count control and the fetch PC stay in fetch_queue.

Test Plan:
- Reset then run with memory returning 0x7C221A14_38600001 → after edge 2: D0inst=0x7C221A14, D1inst=0x38600001, D0valid=D1valid=1, memReadAddr increments by 1 each cycle.
- pop held at 0 with DEPTH=64 → count saturates at 64 (or 62 with one word in flight); memReadEn drops; no entry is overwritten; then pop=2 resumes fetch.
- redirectEn with redirectPc=0x104 → memReadAddr=0x20 next cycle; only the second word of the returned data is queued; count=1, D0inst equals memReadData[32:63].
- redirectEn in the same cycle as a data return and pop=2 → count=0, D0valid=0; the returned data never appears.
- Steady pop=1 while fetching 2 per cycle across >64 instructions → head/tail wrap; D0inst sequence matches program order with no gaps or duplicates.
- reset asserted mid-stream with inflight=1 → outputs are 0 immediately; the first memReadAddr after release is RESET_PC[0:60].
